// File: rtl/scorpion_teaser.sv
`default_nettype none
// ============================================================================
// Module   : scorpion_teaser
// Brief    : Drives the danger input of a scorpion FSM. Each run approaches the
//            scorpion, pokes it, watches the reply and then either pokes again,
//            flees or aborts. It counts pokes and retreats and flags when the
//            scorpion attacked (stung) or the run was aborted (err).
// Revision : 1.0  - first release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  system clock, rising edge
//   reset          in   1  synchronous active-high reset
//   start          in   1  start a run (only looked at in IDLE or DONE)
//   scorpion_state in   4  state code reported by the scorpion FSM
//   danger         out  1  poke stimulus, high only in POKE
//   busy           out  1  high in every state except IDLE and DONE
//   done           out  1  high while in DONE
//   stung          out  1  scorpion attacked after a poke in this run
//   err            out  1  run aborted on timeout or unexpected code
//   poke_count     out  4  pokes issued in this run (saturates at 15)
//   retreat_count  out  4  retreats seen in this run (saturates at 15)
// ============================================================================
module scorpion_teaser #(
    parameter int TICK_CYCLES   = 50000000,
    parameter int TIMEOUT_TICKS = 8,
    parameter int MAX_POKES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] scorpion_state,
    output logic       danger,
    output logic       busy,
    output logic       done,
    output logic       stung,
    output logic       err,
    output logic [3:0] poke_count,
    output logic [3:0] retreat_count
);

    localparam int c_CYC_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_TICK_W = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [c_CYC_W-1:0]  c_CYC_LAST    = c_CYC_W'(TICK_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LIMIT  = c_TICK_W'(TIMEOUT_TICKS);
    localparam logic [3:0]          c_COUNT_MAX   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPROACH = 3'd1,
        ST_POKE     = 3'd2,
        ST_OBSERVE  = 3'd3,
        ST_FLEE     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CYC_W-1:0]  r_cycle_cnt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_stung;
    logic                r_err;
    logic [3:0]          r_poke_count;
    logic [3:0]          r_retreat_count;

    logic w_tick;
    logic w_timeout;
    logic w_is_sensor;
    logic w_is_retreat;
    logic w_is_attack;
    logic w_is_home;
    logic w_run_start;
    logic w_poke_inc;
    logic w_retreat_inc;
    logic w_set_stung;
    logic w_set_err;

    // Scorpion code classes; anything not listed is treated as "other".
    assign w_is_sensor  = (scorpion_state == 4'b0000) ||
                          (scorpion_state == 4'b0011) ||
                          (scorpion_state == 4'b0110);
    assign w_is_retreat = (scorpion_state == 4'b0001) ||
                          (scorpion_state == 4'b0100);
    assign w_is_attack  = (scorpion_state == 4'b0111);
    assign w_is_home    = (scorpion_state == 4'b0000);

    assign w_tick    = (r_cycle_cnt == c_CYC_LAST);
    assign w_timeout = (r_tick_cnt == c_TICK_LIMIT);

    // Next-state and event decode. Code checks are tested before the timeout
    // so a valid reply on the last allowed cycle still wins.
    always_comb begin
        w_state_next  = r_state;
        w_run_start   = 1'b0;
        w_poke_inc    = 1'b0;
        w_retreat_inc = 1'b0;
        w_set_stung   = 1'b0;
        w_set_err     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_APPROACH;
                    w_run_start  = 1'b1;
                end
            end
            ST_APPROACH: begin
                if (w_is_sensor) begin
                    w_state_next = ST_POKE;
                    w_poke_inc   = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                    w_set_err    = 1'b1;
                end
            end
            ST_POKE: begin
                if (!w_is_sensor) begin
                    w_state_next = ST_OBSERVE;
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                    w_set_err    = 1'b1;
                end
            end
            ST_OBSERVE: begin
                // Always resolved in a single cycle.
                if (w_is_retreat) begin
                    w_retreat_inc = 1'b1;
                    if (int'(r_poke_count) < MAX_POKES) begin
                        w_state_next = ST_APPROACH;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else if (w_is_attack) begin
                    w_set_stung  = 1'b1;
                    w_state_next = ST_FLEE;
                end else begin
                    w_state_next = ST_DONE;
                    w_set_err    = 1'b1;
                end
            end
            ST_FLEE: begin
                if (w_is_home) begin
                    w_state_next = ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                    w_set_err    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cycle_cnt     <= '0;
            r_tick_cnt      <= '0;
            r_stung         <= 1'b0;
            r_err           <= 1'b0;
            r_poke_count    <= '0;
            r_retreat_count <= '0;
        end else begin
            r_state <= w_state_next;

            // Timer restarts on every state change so each state gets a full
            // timeout window measured from its entry.
            if (w_state_next != r_state) begin
                r_cycle_cnt <= '0;
                r_tick_cnt  <= '0;
            end else begin
                if (w_tick) begin
                    r_cycle_cnt <= '0;
                end else begin
                    r_cycle_cnt <= r_cycle_cnt + c_CYC_W'(1);
                end
                // Tick count stops at the limit rather than wrapping.
                if (w_tick && !w_timeout) begin
                    r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                end
            end

            if (w_run_start) begin
                r_stung         <= 1'b0;
                r_err           <= 1'b0;
                r_poke_count    <= '0;
                r_retreat_count <= '0;
            end else begin
                if (w_poke_inc && (r_poke_count != c_COUNT_MAX)) begin
                    r_poke_count <= r_poke_count + 4'd1;
                end
                if (w_retreat_inc && (r_retreat_count != c_COUNT_MAX)) begin
                    r_retreat_count <= r_retreat_count + 4'd1;
                end
                if (w_set_stung) begin
                    r_stung <= 1'b1;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Moore outputs decoded from the state register only.
    assign danger        = (r_state == ST_POKE);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done          = (r_state == ST_DONE);
    assign stung         = r_stung;
    assign err           = r_err;
    assign poke_count    = r_poke_count;
    assign retreat_count = r_retreat_count;

endmodule
`default_nettype wire

// File: tb/tb_scorpion_teaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_scorpion_teaser
// Brief    : Directed self-checking bench for scorpion_teaser. Instance A uses
//            MAX_POKES=3, instance B uses MAX_POKES=2; both use a 4-cycle tick
//            and a 3-tick timeout. Scorpion replies are driven by hand.
// Revision : 1.0  - first release
// ============================================================================
module tb_scorpion_teaser;

    logic       clk;
    logic       reset;

    logic       start_a;
    logic [3:0] code_a;
    logic       danger_a, busy_a, done_a, stung_a, err_a;
    logic [3:0] poke_a, retreat_a;

    logic       start_b;
    logic [3:0] code_b;
    logic       danger_b, busy_b, done_b, stung_b, err_b;
    logic [3:0] poke_b, retreat_b;

    int n_checks;
    int n_errors;
    int danger_b_rises;

    scorpion_teaser #(
        .TICK_CYCLES   (4),
        .TIMEOUT_TICKS (3),
        .MAX_POKES     (3)
    ) u_dut_a (
        .clk            (clk),
        .reset          (reset),
        .start          (start_a),
        .scorpion_state (code_a),
        .danger         (danger_a),
        .busy           (busy_a),
        .done           (done_a),
        .stung          (stung_a),
        .err            (err_a),
        .poke_count     (poke_a),
        .retreat_count  (retreat_a)
    );

    scorpion_teaser #(
        .TICK_CYCLES   (4),
        .TIMEOUT_TICKS (3),
        .MAX_POKES     (2)
    ) u_dut_b (
        .clk            (clk),
        .reset          (reset),
        .start          (start_b),
        .scorpion_state (code_b),
        .danger         (danger_b),
        .busy           (busy_b),
        .done           (done_b),
        .stung          (stung_b),
        .err            (err_b),
        .poke_count     (poke_b),
        .retreat_count  (retreat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge danger_b) danger_b_rises++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        danger_b_rises = 0;
        reset   = 1'b1;
        start_a = 1'b0;
        code_a  = 4'b0000;
        start_b = 1'b0;
        code_b  = 4'b0000;
        step(2);

        // Reset state
        check("rst_danger",  8'(danger_a),  8'd0);
        check("rst_busy",    8'(busy_a),    8'd0);
        check("rst_done",    8'(done_a),    8'd0);
        check("rst_stung",   8'(stung_a),   8'd0);
        check("rst_err",     8'(err_a),     8'd0);
        check("rst_poke",    8'(poke_a),    8'd0);
        check("rst_retreat", 8'(retreat_a), 8'd0);
        reset = 1'b0;
        step(1);
        check("idle_no_start_busy", 8'(busy_a), 8'd0);

        // Full run: two retreats then an attack and flee (MAX_POKES=3)
        code_a = 4'b0110; start_a = 1'b1;
        step(1);                                  // -> APPROACH
        start_a = 1'b0;
        check("run_approach_busy",   8'(busy_a),   8'd1);
        check("run_approach_danger", 8'(danger_a), 8'd0);
        step(1);                                  // -> POKE #1
        check("run_poke1_danger", 8'(danger_a), 8'd1);
        check("run_poke1_count",  8'(poke_a),   8'd1);
        code_a = 4'b0001;
        step(1);                                  // -> OBSERVE
        check("run_obs1_danger", 8'(danger_a), 8'd0);
        step(1);                                  // retreat -> APPROACH
        check("run_retreat1", 8'(retreat_a), 8'd1);
        check("run_retreat1_busy", 8'(busy_a), 8'd1);
        code_a = 4'b0011;
        step(1);                                  // -> POKE #2
        check("run_poke2_count", 8'(poke_a), 8'd2);
        code_a = 4'b0100;
        step(2);                                  // OBSERVE, retreat -> APPROACH
        check("run_retreat2", 8'(retreat_a), 8'd2);
        code_a = 4'b0000;
        step(1);                                  // -> POKE #3
        check("run_poke3_count",  8'(poke_a),   8'd3);
        check("run_poke3_danger", 8'(danger_a), 8'd1);
        code_a = 4'b0111;
        step(2);                                  // OBSERVE, attack -> FLEE
        check("run_flee_stung", 8'(stung_a), 8'd1);
        check("run_flee_done",  8'(done_a),  8'd0);
        step(2);
        check("run_flee_hold_busy", 8'(busy_a), 8'd1);
        code_a = 4'b0000;
        step(1);                                  // home -> DONE
        check("run_done",         8'(done_a),    8'd1);
        check("run_done_busy",    8'(busy_a),    8'd0);
        check("run_done_err",     8'(err_a),     8'd0);
        check("run_done_poke",    8'(poke_a),    8'd3);
        check("run_done_retreat", 8'(retreat_a), 8'd2);
        step(3);
        check("done_hold_stung", 8'(stung_a), 8'd1);
        check("done_hold_poke",  8'(poke_a),  8'd3);

        // Approach timeout with an unexpected code; restart clears the counts
        code_a = 4'b0010; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check("restart_clr_poke",    8'(poke_a),    8'd0);
        check("restart_clr_retreat", 8'(retreat_a), 8'd0);
        check("restart_clr_stung",   8'(stung_a),   8'd0);
        step(12);
        check("appr_to_not_yet", 8'(done_a), 8'd0);
        step(1);
        check("appr_to_done", 8'(done_a), 8'd1);
        check("appr_to_err",  8'(err_a),  8'd1);
        check("appr_to_poke", 8'(poke_a), 8'd0);

        // Poke timeout: scorpion never leaves 0000
        code_a = 4'b0000; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check("poke_to_err_clr", 8'(err_a), 8'd0);
        step(1);
        check("poke_to_danger_on", 8'(danger_a), 8'd1);
        step(12);
        check("poke_to_danger_hold", 8'(danger_a), 8'd1);
        step(1);
        check("poke_to_done",   8'(done_a),   8'd1);
        check("poke_to_err",    8'(err_a),    8'd1);
        check("poke_to_danger", 8'(danger_a), 8'd0);
        check("poke_to_poke",   8'(poke_a),   8'd1);

        // Unexpected code seen in OBSERVE
        code_a = 4'b0011; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(1);                                  // POKE
        code_a = 4'b1000;
        step(1);                                  // OBSERVE
        check("obs_bad_busy", 8'(busy_a), 8'd1);
        step(1);
        check("obs_bad_done", 8'(done_a), 8'd1);
        check("obs_bad_err",  8'(err_a),  8'd1);

        // Reset during POKE dominates a concurrent start
        code_a = 4'b0011; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(1);
        check("rst_mid_danger_pre", 8'(danger_a), 8'd1);
        reset = 1'b1; start_a = 1'b1;
        step(1);
        check("rst_mid_danger", 8'(danger_a), 8'd0);
        check("rst_mid_busy",   8'(busy_a),   8'd0);
        check("rst_mid_done",   8'(done_a),   8'd0);
        check("rst_mid_poke",   8'(poke_a),   8'd0);
        reset = 1'b0; start_a = 1'b0;
        step(1);
        check("rst_mid_idle", 8'(busy_a), 8'd0);

        // Start held high through DONE restarts at once
        code_a = 4'b0011; start_a = 1'b1;
        step(2);                                  // APPROACH, POKE
        code_a = 4'b1000;
        step(2);                                  // OBSERVE, DONE (err)
        check("hold_done",     8'(done_a), 8'd1);
        check("hold_done_err", 8'(err_a),  8'd1);
        check("hold_done_poke", 8'(poke_a), 8'd1);
        step(1);                                  // restart
        check("hold_restart_busy", 8'(busy_a), 8'd1);
        check("hold_restart_err",  8'(err_a),  8'd0);
        check("hold_restart_poke", 8'(poke_a), 8'd0);
        start_a = 1'b0;

        // MAX_POKES=2: two retreats finish the run cleanly
        code_b = 4'b0110; start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        step(1);                                  // POKE #1
        code_b = 4'b0001;
        step(2);                                  // OBSERVE, APPROACH
        check("b_retreat1", 8'(retreat_b), 8'd1);
        code_b = 4'b0110;
        step(1);                                  // POKE #2
        code_b = 4'b0001;
        step(2);                                  // OBSERVE, DONE
        check("b_done",    8'(done_b),    8'd1);
        check("b_poke",    8'(poke_b),    8'd2);
        check("b_retreat", 8'(retreat_b), 8'd2);
        check("b_stung",   8'(stung_b),   8'd0);
        check("b_err",     8'(err_b),     8'd0);
        code_b = 4'b0110;
        step(4);
        check("b_no_third_poke", 8'(danger_b_rises), 8'd2);
        check("b_danger_low",    8'(danger_b),       8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
